// File: rtl/mac_dot_ctrl_pkg.sv
// mac_dot_ctrl_pkg: widths, state encoding and ReLU helper
// shared by the dot-product sequencer and its bus interface.
package mac_dot_ctrl_pkg;

  localparam int WORD_BITS = 16;
  localparam int LEN_BITS  = 8;
  localparam int ADDR_BITS = 10;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [LEN_BITS-1:0]  len_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

  typedef enum logic [2:0] {
    MDC_ST_IDLE,
    MDC_ST_FETCH,
    MDC_ST_LATCH,
    MDC_ST_ISSUE,
    MDC_ST_WAIT,
    MDC_ST_ACC,
    MDC_ST_DONE
  } mdc_st_e;

  function automatic word_t relu(
    input word_t v,
    input logic  en
  );
    return (en && v[WORD_BITS-1]) ? '0 : v;
  endfunction

endpackage

// File: rtl/mac_dot_ctrl_if.sv
// mac_dot_ctrl_if: buffer read ports and MAC operand/result bus.
// master = sequencer (strobes, addrs, operands); slave = buffers + MAC.
interface mac_dot_ctrl_if;
  import mac_dot_ctrl_pkg::*;

  logic  x_rd_en;
  logic  w_rd_en;
  addr_t x_addr;
  addr_t w_addr;
  word_t x_data;
  word_t w_data;
  logic  mac_valid;
  word_t mac_s0;
  word_t mac_s1;
  word_t mac_s2;
  logic  mac_d0_valid;
  word_t mac_d0;

  modport master (
    output x_rd_en, w_rd_en, x_addr, w_addr,
    output mac_valid, mac_s0, mac_s1, mac_s2,
    input  x_data, w_data, mac_d0_valid, mac_d0
  );

  modport slave (
    input  x_rd_en, w_rd_en, x_addr, w_addr,
    input  mac_valid, mac_s0, mac_s1, mac_s2,
    output x_data, w_data, mac_d0_valid, mac_d0
  );

endinterface

// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl: sequences len act/weight taps through one MAC, bias + ReLU.
// Ports: CLK, RST, start/len/bases/bias/relu_en in; busy/done/result out; bus.
module mac_dot_ctrl
  import mac_dot_ctrl_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  start,
  input  len_t  len,
  input  addr_t x_base,
  input  addr_t w_base,
  input  word_t bias,
  input  logic  relu_en,
  output logic  busy,
  output logic  done,
  output word_t result,
  mac_dot_ctrl_if.master bus
);

  mdc_st_e st_q, st_d;
  len_t    len_q, len_d;
  len_t    k_q, k_d;
  addr_t   xb_q, xb_d;
  addr_t   wb_q, wb_d;
  logic    relu_q, relu_d;
  word_t   acc_q, acc_d;
  word_t   xq_q, xq_d;
  word_t   wq_q, wq_d;
  word_t   s0_q, s0_d;
  word_t   s1_q, s1_d;
  word_t   s2_q, s2_d;
  logic    pend_q, pend_d;
  word_t   res_q, res_d;

  logic    more;
  logic    last;
  addr_t   off;

  // more: another tap remains after k; last: k is the final tap
  assign more = ({1'b0, k_q} + 9'd1) < {1'b0, len_q};
  assign last = ({1'b0, k_q} + 9'd1) == {1'b0, len_q};

  always_comb begin
    st_d   = st_q;
    len_d  = len_q;
    k_d    = k_q;
    xb_d   = xb_q;
    wb_d   = wb_q;
    relu_d = relu_q;
    acc_d  = acc_q;
    xq_d   = xq_q;
    wq_d   = wq_q;
    s0_d   = s0_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    pend_d = pend_q;
    res_d  = res_q;
    off    = '0;
    bus.x_rd_en   = 1'b0;
    bus.w_rd_en   = 1'b0;
    bus.x_addr    = '0;
    bus.w_addr    = '0;
    bus.mac_valid = 1'b0;

    unique case (st_q)
      MDC_ST_IDLE: begin
        if (start) begin
          len_d  = len;
          xb_d   = x_base;
          wb_d   = w_base;
          relu_d = relu_en;
          acc_d  = bias;
          k_d    = '0;
          if (len == '0) begin
            // result is registered here so it is valid
            // in the same cycle as the done pulse
            res_d = relu(bias, relu_en);
            st_d  = MDC_ST_DONE;
          end else begin
            st_d = MDC_ST_FETCH;
          end
        end
      end
      MDC_ST_FETCH: begin
        bus.x_rd_en = 1'b1;
        bus.w_rd_en = 1'b1;
        bus.x_addr  = xb_q;
        bus.w_addr  = wb_q;
        st_d        = MDC_ST_LATCH;
      end
      MDC_ST_LATCH: begin
        xq_d = bus.x_data;
        wq_d = bus.w_data;
        s0_d = bus.x_data;
        s1_d = bus.w_data;
        s2_d = acc_q;
        st_d = MDC_ST_ISSUE;
      end
      MDC_ST_ISSUE: begin
        bus.mac_valid = 1'b1;
        pend_d        = more;
        // prefetch the next tap while the MAC works
        if (more) begin
          off         = addr_t'(k_q) + addr_t'(1);
          bus.x_rd_en = 1'b1;
          bus.w_rd_en = 1'b1;
          bus.x_addr  = xb_q + off;
          bus.w_addr  = wb_q + off;
        end
        st_d = MDC_ST_WAIT;
      end
      MDC_ST_WAIT: begin
        if (pend_q) begin
          xq_d = bus.x_data;
          wq_d = bus.w_data;
        end
        st_d = MDC_ST_ACC;
      end
      MDC_ST_ACC: begin
        if (bus.mac_d0_valid) begin
          acc_d = bus.mac_d0;
          k_d   = k_q + len_t'(1);
          if (last) begin
            res_d = relu(bus.mac_d0, relu_q);
            st_d  = MDC_ST_DONE;
          end else begin
            // operands only change on entry to ISSUE
            s0_d = xq_q;
            s1_d = wq_q;
            s2_d = bus.mac_d0;
            st_d = MDC_ST_ISSUE;
          end
        end
      end
      MDC_ST_DONE: begin
        st_d = MDC_ST_IDLE;
      end
      default: begin
        st_d = MDC_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= MDC_ST_IDLE;
      len_q  <= '0;
      k_q    <= '0;
      xb_q   <= '0;
      wb_q   <= '0;
      relu_q <= 1'b0;
      acc_q  <= '0;
      xq_q   <= '0;
      wq_q   <= '0;
      s0_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      pend_q <= 1'b0;
      res_q  <= '0;
    end else begin
      st_q   <= st_d;
      len_q  <= len_d;
      k_q    <= k_d;
      xb_q   <= xb_d;
      wb_q   <= wb_d;
      relu_q <= relu_d;
      acc_q  <= acc_d;
      xq_q   <= xq_d;
      wq_q   <= wq_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      pend_q <= pend_d;
      res_q  <= res_d;
    end
  end

  assign busy       = (st_q != MDC_ST_IDLE);
  assign done       = (st_q == MDC_ST_DONE);
  assign result     = res_q;
  assign bus.mac_s0 = s0_q;
  assign bus.mac_s1 = s1_q;
  assign bus.mac_s2 = s2_q;

endmodule

// File: doc/mac_dot_ctrl.md
# mac_dot_ctrl

Sequencer that drives the single pipelined Q9.6 `MAC` datapath to compute one neuron or filter output: a dot product of `len` activation/weight pairs plus a bias, with optional ReLU. It reads both operands from single-port buffers with 1-cycle read latency and issues one MAC operation per tap. It feeds the running sum back through the MAC's accumulate input (`S2_in`). It sits between the layer scheduler (start/done) and the `MAC` instance plus the activation and weight buffers.

## Interface
- `WORD_BITS`, 16: operand and result width, Q9.6 two's complement. Taken from `` `WORD_BITS `` in `common.vh`.
- `LEN_BITS`, 8: width of the tap-count field.
- `ADDR_BITS`, 10: buffer address width.

- `CLK`  in  1  clock; single clock domain.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `len`  in  `LEN_BITS`  tap count (0 allowed); sampled with `start`.
- `x_base`, `w_base`  in  `ADDR_BITS`  base addresses of the activation and weight buffers; sampled with `start`.
- `bias`  in  `WORD_BITS`  initial accumulator value; sampled with `start`.
- `relu_en`  in  1  clamp negative results to 0; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when `result` is updated.
- `result`  out  `WORD_BITS`  final value; held until the next `done`.
- `x_rd_en`, `w_rd_en`  out  1  buffer read strobes.
- `x_addr`, `w_addr`  out  `ADDR_BITS`  buffer read addresses.
- `x_data`, `w_data`  in  `WORD_BITS`  read data, valid 1 cycle after the strobe.
- `mac_valid`  out  1  drives `S0_valid_in`, `S1_valid_in` and `S2_valid_in` together.
- `mac_s0`, `mac_s1`, `mac_s2`  out  `WORD_BITS`  activation, weight, accumulate-in.
- `mac_d0_valid`  in  1  MAC `D0_valid`.
- `mac_d0`  in  `WORD_BITS`  MAC `D0_out`.

## Operation
- States: IDLE, FETCH, LATCH, ISSUE, WAIT, ACC, DONE.
- **IDLE**
  - `start`=1 captures `len`, both bases, `relu_en`, and sets `acc`<=`bias`, `k`<=0.
  - Next state is DONE if `len`=0, otherwise FETCH.
- **FETCH:** assert both read strobes at `base+0`; go to LATCH.
- **LATCH:** `xq`<=`x_data`, `wq`<=`w_data`; go to ISSUE.
- **ISSUE:**
  - Drive `mac_valid`=1 with S0=`xq`, S1=`wq`, S2=`acc`.
  - If `k+1`<`len`, also assert the read strobes at `base+k+1`.
  - Go to WAIT.
- **WAIT:** if a read was issued, latch `xq`/`wq`; go to ACC.
- **ACC:**
  - Hold in ACC until `mac_d0_valid`=1.
  - On that cycle: `acc`<=`mac_d0`, `k`<=`k+1`.
  - Go to DONE if `k`=`len-1`, else ISSUE.
- **DONE:**
  - `result`<=(`relu_en` && `acc`<0) ? 0 : `acc`; `done`=1.
  - Return to IDLE.
- `mac_valid` is 0 in all states except ISSUE. `mac_s*` hold their last values when not valid.
- Arithmetic: the controller does no arithmetic beyond the ReLU select. Overflow wraps inside the MAC; it is not saturated.
- Addresses wrap modulo 2^`ADDR_BITS`.
- `start` while `busy` is ignored; there is no queueing.
- A `mac_d0_valid` pulse outside ACC is ignored.

## Timing
- Reset values:
  - All outputs 0, including `result`, `done` and `mac_valid`.
  - State IDLE; `acc`, `k`, `xq`, `wq` cleared.
  - Reset mid-operation aborts at once: no `done` pulse, `mac_valid` drops in the same cycle.
- Per-tap cadence with the 2-cycle `MAC`: ISSUE at t, `mac_d0_valid` at t+2, next ISSUE at t+3. That is 3 cycles per tap.
- Latency, with `start` sampled at cycle s:
  - `len`=L>0: `done` at cycle s+3+3L.
  - `len`=0: `done` at s+1, `result`=`bias` after ReLU.
- A new `start` is accepted in the cycle after `done` at the earliest.
- A slower MAC is tolerated: extra cycles in ACC stretch the timing, but the result is unchanged.

## Structure
- Add state encodings to `common.vh` as `MDC_ST_*` defines. `WORD_BITS` is already defined there.
- Single flat module; no sub-module.
- The `MAC` instance and both buffers are instantiated by the parent layer block.

## Test plan
Bench uses the real `MAC` plus two behavioural 1-cycle-latency RAMs. Values are Q9.6, where 1.0 = 0x0040.
- `len`=3, x={1.0, 2.0, -0.5}, w={0.5, 0.25, 2.0}, `bias`=0.25, ReLU off -> `result`=0x0010 (0.25), `done` exactly at s+12, `busy` high s+1..s+12.
- `len`=2, x={-1.0, -1.0}, w={1.0, 2.0}, `bias`=0 -> `result`=0xFF40 with ReLU off; 0x0000 with ReLU on.
- `len`=0, `bias`=-1.5, ReLU off -> `done` at s+1, `result`=0xFFA0, no read strobes, no `mac_valid`.
- `start` reasserted while `busy` with different operands -> ignored; first result unchanged, exactly one `done`.
- `RST` asserted in the second ACC of a `len`=4 job -> all outputs 0 immediately, no `done`. A following job with `len`=1, x=1.0, w=1.0, `bias`=0 -> `result`=0x0040.
- MAC stubbed with `mac_d0_valid` delayed to t+4 -> cadence becomes 5 cycles per tap; result identical to the first scenario.
